// File: rtl/anabellek_yanitlayici.sv
// rtl/anabellek_yanitlayici.sv - iomem word responder driving an 8-bit asynchronous SRAM
// Each word request becomes four byte lanes; write lanes with a clear strobe are skipped.
module anabellek_yanitlayici #(
   parameter int ADR_W    = 19,
   parameter int WAIT_CYC = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             iomem_valid,
   output logic             iomem_ready,
   input  logic [3:0]       iomem_wstrb,
   input  logic [31:0]      iomem_addr,
   input  logic [31:0]      iomem_wdata,
   output logic [31:0]      iomem_rdata,
   output logic             sram_ce_n,
   output logic             sram_oe_n,
   output logic             sram_we_n,
   output logic [ADR_W-1:0] sram_addr,
   output logic [7:0]       sram_dq_o,
   output logic             sram_dq_oe,
   input  logic [7:0]       sram_dq_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WS   = 3'd2;
   localparam logic [2:0] S_WP   = 3'd3;
   localparam logic [2:0] S_WH   = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC);

   logic [2:0]       st_q, st_d;
   logic [1:0]       lane_q, lane_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [ADR_W-3:0] addr_q, addr_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             ce_n_q, ce_n_d;
   logic             oe_n_q, oe_n_d;
   logic             we_n_q, we_n_d;
   logic             dq_oe_q, dq_oe_d;
   logic [ADR_W-1:0] sram_addr_q, sram_addr_d;
   logic [7:0]       dq_o_q, dq_o_d;
   logic [3:0]       lanes_above;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{iomem_addr[31:ADR_W], iomem_addr[1:0]};

   function automatic logic [1:0] low_lane(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   always_comb begin
      st_d        = st_q;
      lane_d      = lane_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      lanes_above = wstrb_q & (4'b1110 << lane_q);

      case (st_q)
         S_IDLE: begin
            if (iomem_valid) begin
               addr_d  = iomem_addr[ADR_W-1:2];
               wstrb_d = iomem_wstrb;
               wdata_d = iomem_wdata;
               cnt_d   = 3'd0;
               if (iomem_wstrb == 4'b0000) begin
                  st_d   = S_RD;
                  lane_d = 2'd0;
               end else begin
                  st_d   = S_WS;
                  lane_d = low_lane(iomem_wstrb);
               end
            end
         end
         S_RD: begin
            if (cnt_q == WAIT_LAST) begin
               rdata_d[8*lane_q +: 8] = sram_dq_i;
               cnt_d = 3'd0;
               if (lane_q == 2'd3) st_d = S_DONE;
               else                lane_d = lane_q + 2'd1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_WS: begin
            st_d  = S_WP;
            cnt_d = 3'd0;
         end
         S_WP: begin
            if (cnt_q == WAIT_LAST) st_d = S_WH;
            else                    cnt_d = cnt_q + 3'd1;
         end
         S_WH: begin
            // Skip straight to the next strobed lane so clear lanes cost nothing.
            if (lanes_above != 4'b0000) begin
               st_d   = S_WS;
               lane_d = low_lane(lanes_above);
            end else begin
               st_d = S_DONE;
            end
         end
         S_DONE:  st_d = S_IDLE;
         default: st_d = S_IDLE;
      endcase

      // Pad controls are decoded from the next state so they toggle with the state flop.
      ready_d     = (st_d == S_DONE);
      ce_n_d      = !((st_d == S_RD) || (st_d == S_WS) || (st_d == S_WP) || (st_d == S_WH));
      oe_n_d      = (st_d != S_RD);
      we_n_d      = (st_d != S_WP);
      dq_oe_d     = (st_d == S_WS) || (st_d == S_WP) || (st_d == S_WH);
      sram_addr_d = {addr_d, lane_d};
      dq_o_d      = wdata_d[8*lane_d +: 8];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q        <= S_IDLE;
         lane_q      <= 2'd0;
         cnt_q       <= 3'd0;
         addr_q      <= '0;
         wstrb_q     <= 4'd0;
         wdata_q     <= 32'd0;
         rdata_q     <= 32'd0;
         ready_q     <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
         sram_addr_q <= '0;
         dq_o_q      <= 8'd0;
      end else begin
         st_q        <= st_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wstrb_q     <= wstrb_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         dq_oe_q     <= dq_oe_d;
         sram_addr_q <= sram_addr_d;
         dq_o_q      <= dq_o_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign sram_ce_n   = ce_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_o   = dq_o_q;
   assign sram_dq_oe  = dq_oe_q;

endmodule
